// File: rtl/multifunction_register_pkg.sv
// Shared opcode definitions for the multifunction register and its clients.
package multifunction_register_pkg;

    localparam int OPCODE_WIDTH = 3;

    localparam logic [OPCODE_WIDTH-1:0] NONE                = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] CLR                 = 3'd1;
    localparam logic [OPCODE_WIDTH-1:0] PARALLEL_LOAD       = 3'd2;
    localparam logic [OPCODE_WIDTH-1:0] SERIAL_MSB_LOAD     = 3'd3;
    localparam logic [OPCODE_WIDTH-1:0] SERIAL_LSB_LOAD     = 3'd4;
    localparam logic [OPCODE_WIDTH-1:0] SHIFT_LOGICAL_LEFT  = 3'd5;
    localparam logic [OPCODE_WIDTH-1:0] SHIFT_LOGICAL_RIGHT = 3'd6;

endpackage

// File: rtl/multifunction_register_next_state.sv
// Combinational next-state mux: picks the new register word from the current
// contents, the opcode and the serial/parallel inputs.
module register_next_state
    import multifunction_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]        q,
    input  logic [OPCODE_WIDTH-1:0] ctrl,
    input  logic                    serial_data_input,
    input  logic [WIDTH-1:0]        parallel_data_input,
    output logic [WIDTH-1:0]        next_q
);

    // Opcode decode; unused and unknown codes fall through to hold.
    always_comb begin
        next_q = q;
        case (ctrl)
            NONE:                next_q = q;
            CLR:                 next_q = {WIDTH{1'b0}};
            PARALLEL_LOAD:       next_q = parallel_data_input;
            SERIAL_MSB_LOAD:     next_q = {serial_data_input, q[WIDTH-1:1]};
            SERIAL_LSB_LOAD:     next_q = {q[WIDTH-2:0], serial_data_input};
            SHIFT_LOGICAL_LEFT:  next_q = {q[WIDTH-2:0], 1'b0};
            SHIFT_LOGICAL_RIGHT: next_q = {1'b0, q[WIDTH-1:1]};
            default:             next_q = q;
        endcase
    end

endmodule

// File: rtl/multifunction_register.sv
// Multifunction register: a reset-qualified flip-flop bank fed by the
// opcode-driven next-state mux; the output is the flop contents directly.
module multifunction_register
    import multifunction_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic [OPCODE_WIDTH-1:0] ctrl,
    input  logic                    serial_data_input,
    input  logic [WIDTH-1:0]        parallel_data_input,
    output logic [WIDTH-1:0]        data_output
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_q_s;

    register_next_state #(
        .WIDTH(WIDTH)
    ) u_next_state (
        .q                   (q_r),
        .ctrl                (ctrl),
        .serial_data_input   (serial_data_input),
        .parallel_data_input (parallel_data_input),
        .next_q              (next_q_s)
    );

    // State register; reset wins over every opcode.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            q_r <= next_q_s;
        end
    end

    assign data_output = q_r;

endmodule

// File: tb/tb_multifunction_register.sv
// Directed and randomized scoreboard bench for multifunction_register at
// widths 8 (directed), 2 and 16 (random against a shift-operator model).
module tb_multifunction_register;
    import multifunction_register_pkg::*;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        serial;
    logic [2:0]  ctrl8, ctrl2, ctrl16;
    logic [7:0]  par8,  out8;
    logic [1:0]  par2,  out2;
    logic [15:0] par16, out16;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp8_q[$];
    string       tag8_q[$];
    logic [1:0]  exp2_q[$];
    logic [15:0] exp16_q[$];

    logic [1:0]  m2;
    logic [15:0] m16;

    always #5 clk = ~clk;

    multifunction_register #(.WIDTH(8)) dut8 (
        .clk(clk), .sync_reset(sync_reset), .ctrl(ctrl8),
        .serial_data_input(serial), .parallel_data_input(par8), .data_output(out8));
    multifunction_register #(.WIDTH(2)) dut2 (
        .clk(clk), .sync_reset(sync_reset), .ctrl(ctrl2),
        .serial_data_input(serial), .parallel_data_input(par2), .data_output(out2));
    multifunction_register #(.WIDTH(16)) dut16 (
        .clk(clk), .sync_reset(sync_reset), .ctrl(ctrl16),
        .serial_data_input(serial), .parallel_data_input(par16), .data_output(out16));

    // Reference behaviour written with shift operators and a width mask.
    function automatic logic [15:0] model(input logic [15:0] q, input int w,
                                          input logic [2:0] c, input logic s,
                                          input logic [15:0] p);
        logic [15:0] mask;
        logic [15:0] r;
        mask = 16'h0000;
        for (int i = 0; i < w; i++) mask[i] = 1'b1;
        q = q & mask;
        case (c)
            3'd1:    r = 16'h0000;
            3'd2:    r = p;
            3'd3:    r = (q >> 1) | ({15'd0, s} << (w - 1));
            3'd4:    r = (q << 1) | {15'd0, s};
            3'd5:    r = q << 1;
            3'd6:    r = q >> 1;
            default: r = q;
        endcase
        return r & mask;
    endfunction

    task automatic step8(input logic rst, input logic [2:0] c, input logic s,
                         input logic [7:0] p, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        string      t;
        sync_reset = rst;
        ctrl8      = c;
        serial     = s;
        par8       = p;
        exp8_q.push_back(exp);
        tag8_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp8_q.pop_front();
        t = tag8_q.pop_front();
        checks++;
        assert (out8 === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, out8, e);
        end
    endtask

    initial begin
        logic [1:0]  e2;
        logic [15:0] e16;
        sync_reset = 1'b1;
        ctrl8  = NONE;
        ctrl2  = NONE;
        ctrl16 = NONE;
        serial = 1'b0;
        par8   = 8'h00;
        par2   = 2'b00;
        par16  = 16'h0000;

        // Reset with arbitrary opcodes, including a load held off by reset.
        step8(1'b1, SHIFT_LOGICAL_LEFT, 1'b1, 8'hFF, 8'h00, "reset_edge1");
        step8(1'b1, 3'd7,               1'b0, 8'hFF, 8'h00, "reset_edge2");
        step8(1'b1, PARALLEL_LOAD,      1'b1, 8'hA5, 8'h00, "reset_over_load");
        step8(1'b0, SERIAL_MSB_LOAD,    1'b1, 8'hxx, 8'h80, "first_after_reset");

        step8(1'b0, PARALLEL_LOAD,   1'bx, 8'hC3, 8'hC3, "pload_c3");
        step8(1'b0, SERIAL_MSB_LOAD, 1'b0, 8'hxx, 8'h61, "smsb_s0");
        step8(1'b0, SERIAL_MSB_LOAD, 1'b1, 8'hxx, 8'hB0, "smsb_s1");

        step8(1'b0, PARALLEL_LOAD,   1'bx, 8'hC3, 8'hC3, "pload_c3_b");
        step8(1'b0, SERIAL_LSB_LOAD, 1'b1, 8'hxx, 8'h87, "slsb_s1");
        step8(1'b0, SERIAL_LSB_LOAD, 1'b0, 8'hxx, 8'h0E, "slsb_s0");

        step8(1'b0, PARALLEL_LOAD,       1'bx, 8'h81, 8'h81, "pload_81");
        step8(1'b0, SHIFT_LOGICAL_LEFT,  1'b1, 8'hxx, 8'h02, "shl_81");
        step8(1'b0, PARALLEL_LOAD,       1'bx, 8'h81, 8'h81, "pload_81_b");
        step8(1'b0, SHIFT_LOGICAL_RIGHT, 1'b1, 8'hxx, 8'h40, "shr_81");

        step8(1'b0, PARALLEL_LOAD, 1'bx, 8'hFF, 8'hFF, "pload_ff");
        for (int i = 1; i <= 8; i++) begin
            step8(1'b0, SHIFT_LOGICAL_RIGHT, 1'b1, 8'hxx, 8'hFF >> i, "shr_ff_chain");
        end

        step8(1'b0, PARALLEL_LOAD, 1'bx, 8'h5A, 8'h5A, "pload_5a");
        for (int i = 0; i < 3; i++) begin
            step8(1'b0, NONE, 1'bx, 8'hxx, 8'h5A, "hold_none");
        end
        step8(1'b0, 3'd7,   1'bx, 8'hxx, 8'h5A, "hold_op7");
        step8(1'b0, 3'bxxx, 1'bx, 8'hxx, 8'h5A, "hold_ctrl_x");
        step8(1'b0, CLR,    1'bx, 8'hxx, 8'h00, "clear");

        // Random sweep on the narrow and wide instances.
        ctrl8 = NONE;
        m2    = 2'b00;
        m16   = 16'h0000;
        for (int i = 0; i < 1000; i++) begin
            sync_reset = ($urandom_range(0, 49) == 0);
            ctrl2      = 3'($urandom_range(0, 7));
            ctrl16     = 3'($urandom_range(0, 7));
            serial     = 1'($urandom_range(0, 1));
            par2       = 2'($urandom);
            par16      = 16'($urandom);
            if (sync_reset) begin
                m2  = 2'b00;
                m16 = 16'h0000;
            end else begin
                m2  = 2'(model({14'd0, m2}, 2, ctrl2, serial, {14'd0, par2}));
                m16 = model(m16, 16, ctrl16, serial, par16);
            end
            exp2_q.push_back(m2);
            exp16_q.push_back(m16);
            @(posedge clk);
            #1;
            e2  = exp2_q.pop_front();
            e16 = exp16_q.pop_front();
            checks++;
            assert (out2 === e2) else begin
                failures++;
                $error("FAIL sweep_w2 cycle=%0d observed=%h expected=%h", i, out2, e2);
            end
            checks++;
            assert (out16 === e16) else begin
                failures++;
                $error("FAIL sweep_w16 cycle=%0d observed=%h expected=%h", i, out16, e16);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
